fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, number of fetch-buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_pc  output  10  word index to instruction_memory pc.
REQ-006 SHALL have port imem_instruction  input  32  instruction_memory read data, valid one cycle after imem_pc.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port out_valid  output  1  decode-side data valid.
REQ-010 SHALL have port out_ready  input  1  decode stage accepts.
REQ-011 SHALL have port out_instr  output  32  instruction to decode.
REQ-012 SHALL have port out_pc  output  32  byte address of out_instr.

Function
REQ-013 SHALL hold a 32-bit fetch PC and drive imem_pc = fetch_pc[11:2] combinationally.
REQ-014 SHALL implement FSM states BOOT, FETCH and FLUSH.
REQ-015 BOOT, entered on reset, SHALL last exactly one cycle, issue no request, and then go to FETCH.
REQ-016 In FETCH, a request SHALL issue when buffer occupancy plus in-flight requests is less than BUF_DEPTH, and fetch_pc SHALL then advance by 4.
REQ-017 Each response SHALL be written to the buffer tagged with its request PC, one cycle after issue.
REQ-018 out_valid SHALL equal buffer non-empty; out_instr/out_pc SHALL present the oldest entry, and it SHALL pop when out_valid and out_ready are both high.
REQ-019 out_instr/out_pc SHALL stay stable while out_valid is high and out_ready is low.
REQ-020 Steady state with out_ready held high SHALL deliver one instruction per cycle; first out_valid SHALL occur in the third cycle after rst deasserts.
REQ-021 On redirect_valid, the buffer SHALL clear, fetch_pc SHALL load {redirect_pc[31:2],2'b00}, and the FSM SHALL enter FLUSH.
REQ-022 FLUSH SHALL last one cycle, discard any response arriving in it, issue a request at the new PC, and return to FETCH.
REQ-023 Redirect and pop in the same cycle: the pop completes, then the flush applies; redirect SHALL take priority over a normal request or write.
REQ-024 Redirect during FLUSH SHALL restart FLUSH with the newer target.
REQ-025 fetch_pc SHALL wrap modulo 2^32; imem_pc SHALL wrap every 4 KiB.
REQ-026 Buffer SHALL never overflow, and SHALL never pop when empty.

Reset
REQ-027 While rst is high: fetch_pc=RESET_PC, state=BOOT, buffer empty, no in-flight request, out_valid=0, out_instr=0, out_pc=0.
REQ-028 Reset asserted mid-operation SHALL abandon all in-flight responses, with no stale instruction delivered after release.

Configuration
REQ-029 With macro FETCH_PERF_CNT_EN defined, SHALL add output perf_fetch_cnt (32) counting pops, reset to 0 and wrapping at 2^32.
REQ-030 Without FETCH_PERF_CNT_EN, the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, XLEN=32, IMEM_AW=10 and the NOP constant 32'h0000_0013.
REQ-032 The buffer SHALL be a sub-module fetch_fifo (parameterised depth, PC+instr payload, push/pop/full/empty).

Verification
REQ-033 Reset release with out_ready=1 and imem words 0..4 = A..E -> out_pc 0,4,8,12 on consecutive cycles carrying A,B,C,D; first valid in the third cycle.
REQ-034 out_ready=0 for 5 cycles after the first valid -> out_pc stays 0, imem_pc advances by at most BUF_DEPTH, and there is no loss or duplication on resume.
REQ-035 redirect_valid with redirect_pc=0x40 while the buffer is full -> the next delivered out_pc=0x40, with no 0x08/0x0C delivered afterward.
REQ-036 Redirect to 0x43, then again to 0x80 one cycle later -> the first delivered out_pc=0x80.
REQ-037 Redirect to 0xFFC with sequential fetch -> out_pc 0xFFC then 0x1000, and imem_pc goes 1023 then 0.
REQ-038 rst pulse mid-stream -> out_valid=0 immediately, restart at RESET_PC, perf_fetch_cnt=0 (if FETCH_PERF_CNT_EN).

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: types and constants shared by the instruction fetch unit.
//   XLEN          - datapath / address width
//   IMEM_AW       - instruction memory word-index width
//   NOP           - canonical no-op encoding (addi x0,x0,0)
//   fetch_state_e - fetch FSM states
//   fetch_entry_t - fetch-buffer payload (request PC + instruction word)
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int IMEM_AW = 10;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   push      - write wr_data (ignored when full unless a pop frees a slot)
//   pop       - drop the head entry (ignored when empty)
//   flush     - discard all entries; overrides push and pop
//   wr_data   - entry to write
//   rd_data   - head (oldest) entry
//   full, empty, count - occupancy status
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW:0]     count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a small decoupling buffer
// and branch/jump redirect support.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   imem_pc           - word index presented to instruction memory
//   imem_instruction  - memory read data, one cycle after imem_pc
//   redirect_valid/pc - redirect request and target byte address
//   out_valid/ready   - decode-side handshake
//   out_instr/out_pc  - oldest buffered instruction and its byte address
//   perf_fetch_cnt    - delivered-instruction counter, present only when
//                       the macro FETCH_PERF_CNT_EN is defined
// BUF_DEPTH legal values: 2, 4.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_pc,
  input  logic [XLEN-1:0]    imem_instruction,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]    perf_fetch_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] fetch_pc_nxt_s;
  logic            inflight_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            space_ok_s;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   occ_s;
  logic            full_s;
  logic            empty_s;
  fetch_entry_t    head_s;
  fetch_entry_t    wr_entry_s;

  assign imem_pc = fetch_pc_r[IMEM_AW+1:2];
  assign pop_s   = !empty_s && out_ready;

  // Occupancy after this cycle's pop plus the outstanding response; a new
  // request is allowed only if its response is guaranteed a free slot.
  assign occ_s      = count_s - CW'(pop_s) + CW'(inflight_r);
  assign space_ok_s = (occ_s < CW'(BUF_DEPTH));

  // A response lands one cycle after its request; a redirect discards it.
  assign push_s     = inflight_r && !redirect_valid && (state_r != FLUSH) &&
                      (!full_s || pop_s);
  assign wr_entry_s = '{pc: inflight_pc_r, instr: imem_instruction};

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (redirect_valid),
    .wr_data (wr_entry_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  // Next-state, request issue and fetch-PC update; redirect wins over issue.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    issue_s        = 1'b0;
    case (state_r)
      BOOT: begin
        if (redirect_valid) begin
          state_nxt_s    = FLUSH;
          fetch_pc_nxt_s = align_word(redirect_pc);
        end else begin
          state_nxt_s = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          state_nxt_s    = FLUSH;
          fetch_pc_nxt_s = align_word(redirect_pc);
        end else if (space_ok_s) begin
          issue_s        = 1'b1;
          fetch_pc_nxt_s = fetch_pc_r + 32'd4;
        end else begin
          issue_s = 1'b0;
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          state_nxt_s    = FLUSH;
          fetch_pc_nxt_s = align_word(redirect_pc);
        end else begin
          state_nxt_s    = FETCH;
          issue_s        = 1'b1;
          fetch_pc_nxt_s = fetch_pc_r + 32'd4;
        end
      end
      default: begin
        state_nxt_s    = BOOT;
        fetch_pc_nxt_s = RESET_PC;
      end
    endcase
  end

  // FSM state, fetch PC and the single outstanding-request tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
      end
    end
  end

  // Present the head entry; outputs read as zero whenever the buffer is empty.
  always_comb begin
    out_valid = !empty_s;
    if (empty_s) begin
      out_instr = '0;
      out_pc    = '0;
    end else begin
      out_instr = head_s.instr;
      out_pc    = head_s.pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_cnt_r;

  // Count instructions accepted by decode; wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_r <= '0;
    end else if (pop_s) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_fetch_cnt = perf_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Expected deliveries come
// from a stream model: after reset or a redirect to T, decode must see the
// word-aligned addresses T, T+4, T+8 ... in order, each carrying mem[pc[11:2]].
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif

  logic [31:0] mem [1024];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  int          delivered = 0;
  int          pops_since_reset = 0;
  logic        hold = 1'b0;
  logic        redir_prev = 1'b0;
  logic [31:0] hold_pc, hold_instr;
  logic [9:0]  prev_imem = 10'd0;
  logic        saw_wrap = 1'b0;
  logic [31:0] reset_pc_v;

  typedef struct {
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [9:0]  exp_imem;
  } vec_t;
  vec_t tbl [7];

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_instruction <= mem[imem_pc];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs, check outputs against the stream model, advance.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, hold_pc);
      check("hold_instr", out_instr, hold_instr);
    end
    if (redir_prev) check("flush_empty", 32'(out_valid), 32'd0);
    if (out_valid && rdy) begin
      word = mem[exp_pc[11:2]];
      check("pop_pc", out_pc, exp_pc);
      check("pop_instr", out_instr, word);
      exp_pc = exp_pc + 32'd4;
      delivered++;
      pops_since_reset++;
    end
    hold       = out_valid && !rdy && !rv;
    hold_pc    = out_pc;
    hold_instr = out_instr;
    redir_prev = rv;
    if (rv) exp_pc = rpc & 32'hFFFF_FFFC;
    if (prev_imem == 10'd1023 && imem_pc == 10'd0) saw_wrap = 1'b1;
    prev_imem = imem_pc;
    @(posedge clk);
    #1;
  endtask

  // Assert reset (possibly mid-cycle), check reset outputs, release after an edge.
  task automatic do_reset();
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #1;
    check("rst_valid_now", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_imem_pc", 32'(imem_pc), 32'(reset_pc_v[11:2]));
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf", perf_fetch_cnt, 32'd0);
`endif
    rst              = 1'b0;
    exp_pc           = RESET_PC;
    hold             = 1'b0;
    redir_prev       = 1'b0;
    pops_since_reset = 0;
    prev_imem        = imem_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    logic [9:0]  im0;
    logic [31:0] word;
    reset_pc_v = RESET_PC;
    for (int i = 0; i < 1024; i++) mem[i] = ($urandom() & 32'hFFFF_FC00) | 32'(i);

    // Cycle-by-cycle view after reset release with decode always ready.
    tbl[0] = '{1'b1, 1'b0, 32'h0, 10'd0};
    tbl[1] = '{1'b1, 1'b0, 32'h0, 10'd0};
    tbl[2] = '{1'b1, 1'b0, 32'h0, 10'd1};
    tbl[3] = '{1'b1, 1'b1, 32'h0, 10'd2};
    tbl[4] = '{1'b1, 1'b1, 32'h4, 10'd3};
    tbl[5] = '{1'b1, 1'b1, 32'h8, 10'd4};
    tbl[6] = '{1'b1, 1'b1, 32'hC, 10'd5};

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      out_ready = tbl[i].rdy;
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_imem_pc", i), 32'(imem_pc), 32'(tbl[i].exp_imem));
      if (tbl[i].exp_valid) begin
        word = mem[tbl[i].exp_pc[11:2]];
        check($sformatf("tbl%0d_pc", i), out_pc, tbl[i].exp_pc);
        check($sformatf("tbl%0d_instr", i), out_instr, word);
      end
      @(posedge clk);
      #1;
    end
    exp_pc = 32'h10;
    pops_since_reset = 4;
    d0 = delivered;
    repeat (10) cycle(1'b1, 1'b0, 32'd0);
    check("steady_rate", 32'(delivered - d0), 32'd10);

    // Decode stall right after the first valid instruction.
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    check("stall_first_valid", 32'(out_valid), 32'd1);
    im0 = imem_pc;
    repeat (5) cycle(1'b0, 1'b0, 32'd0);
    check("stall_out_pc", out_pc, 32'd0);
    check("stall_imem_adv", 32'(int'(10'(imem_pc - im0)) <= BUF_DEPTH), 32'd1);
    d0 = delivered;
    repeat (8) cycle(1'b1, 1'b0, 32'd0);
    check("stall_resume", 32'((delivered - d0) >= 6), 32'd1);

    // Redirect to 0x40 while the buffer is full with 0x08/0x0C.
    do_reset();
    repeat (5) cycle(1'b1, 1'b0, 32'd0);
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    check("full_head_pc", out_pc, 32'h8);
    cycle(1'b0, 1'b1, 32'h40);
    d0 = delivered;
    repeat (8) cycle(1'b1, 1'b0, 32'd0);
    check("redir_deliver", 32'((delivered - d0) >= 4), 32'd1);

    // Back-to-back redirects: the newer target wins.
    cycle(1'b1, 1'b1, 32'h43);
    cycle(1'b1, 1'b1, 32'h80);
    d0 = delivered;
    repeat (8) cycle(1'b1, 1'b0, 32'd0);
    check("redir2_deliver", 32'((delivered - d0) >= 4), 32'd1);

    // 4 KiB wrap of the memory index.
    saw_wrap = 1'b0;
    cycle(1'b1, 1'b1, 32'hFFC);
    d0 = delivered;
    repeat (6) cycle(1'b1, 1'b0, 32'd0);
    check("imem_wrap", 32'(saw_wrap), 32'd1);
    check("wrap_deliver", 32'((delivered - d0) >= 3), 32'd1);

    // Randomised traffic, including targets near the 2^32 boundary.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      logic        rdy, rv;
      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 1) == 0) tgt = $urandom();
      else                           tgt = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      cycle(rdy, rv, tgt);
    end
    d0 = delivered;
    repeat (10) cycle(1'b1, 1'b0, 32'd0);
    check("random_drain", 32'((delivered - d0) >= 5), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_count", perf_fetch_cnt, 32'(pops_since_reset));
`endif

    // Reset pulse mid-stream: nothing stale may come out afterwards.
    #3;
    do_reset();
    d0 = delivered;
    repeat (8) cycle(1'b1, 1'b0, 32'd0);
    check("post_reset_deliver", 32'((delivered - d0) >= 4), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_after_reset", perf_fetch_cnt, 32'(pops_since_reset));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
